// File: rtl/spi_master.sv
// SPI master: sends one WIDTH-bit word MSB-first on mosi and captures a word from miso.
// Define SPI_MASTER_LOOPBACK_EN to sample mosi instead of miso for a board self-test.
module spi_master #(
  parameter int WIDTH       = 32,
  parameter int HALF_PERIOD = 4,
  parameter int CS_GAP      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] d,
  input  logic             miso,
  output logic             sck,
  output logic             mosi,
  output logic             cs_n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q
);

  localparam int TMAX = (HALF_PERIOD > CS_GAP) ? HALF_PERIOD : CS_GAP;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam logic [TW-1:0] HP_LAST  = TW'(HALF_PERIOD - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'((CS_GAP > 0) ? CS_GAP - 1 : 0);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_GAP
  } state_t;

  state_t           r_state;
  logic [TW-1:0]    r_tmr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_tx;
  logic [WIDTH-1:0] r_rx;
  logic [WIDTH-1:0] r_q;
  logic             r_sck, r_mosi, r_cs_n, r_busy, r_done;
  logic             w_hp_end;
  logic             w_sample;

  assign w_hp_end = (r_tmr == HP_LAST);

`ifdef SPI_MASTER_LOOPBACK_EN
  assign w_sample = r_mosi;
`else
  assign w_sample = miso;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_cnt   <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_q     <= '0;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tmr <= '0;
          if (start) begin
            r_tx    <= d;
            r_rx    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_cs_n  <= 1'b0;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_hp_end) begin
            r_tmr   <= '0;
            r_sck   <= 1'b1;
            r_mosi  <= r_tx[WIDTH-1];
            r_tx    <= {r_tx[WIDTH-2:0], 1'b0};
            r_state <= S_HIGH;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        S_HIGH: begin
          if (w_hp_end) begin
            r_tmr   <= '0;
            r_sck   <= 1'b0;
            r_rx    <= {r_rx[WIDTH-2:0], w_sample};
            r_state <= S_LOW;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        S_LOW: begin
          if (w_hp_end) begin
            r_tmr <= '0;
            r_cnt <= r_cnt + CW'(1);
            // Last bit received: park sck low for the hold phase.
            if (r_cnt == CNT_LAST) begin
              r_state <= S_HOLD;
            end else begin
              r_sck   <= 1'b1;
              r_mosi  <= r_tx[WIDTH-1];
              r_tx    <= {r_tx[WIDTH-2:0], 1'b0};
              r_state <= S_HIGH;
            end
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        S_HOLD: begin
          if (w_hp_end) begin
            r_tmr  <= '0;
            r_q    <= r_rx;
            r_done <= 1'b1;
            r_cs_n <= 1'b1;
            r_mosi <= 1'b0;
            if (CS_GAP == 0) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_GAP;
            end
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        S_GAP: begin
          if (r_tmr == GAP_LAST) begin
            r_tmr   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sck  = r_sck;
  assign mosi = r_mosi;
  assign cs_n = r_cs_n;
  assign busy = r_busy;
  assign done = r_done;
  assign q    = r_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: randomized frames against a slave model and a frame-level reference.
module tb_spi_master;

  localparam int WIDTH   = 32;
  localparam int HP      = 4;
  localparam int GAP     = 2;
  localparam int CS_LOW  = HP * (2 * WIDTH + 2);
  localparam int IDLE_HI = GAP + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] d = '0;
  logic             miso = 1'b0;
  logic             sck, mosi, cs_n, busy, done;
  logic [WIDTH-1:0] q;

  spi_master #(.WIDTH(WIDTH), .HALF_PERIOD(HP), .CS_GAP(GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .d(d), .miso(miso),
    .sck(sck), .mosi(mosi), .cs_n(cs_n), .busy(busy), .done(done), .q(q)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Slave: presents its word MSB-first, advancing after each sck falling edge.
  logic [WIDTH-1:0] slave_word = '0;
  bit               slave_en = 1'b1;
  initial begin
    int  idx;
    logic prev_sck;
    idx = 0;
    prev_sck = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (cs_n) idx = 0;
      else if (prev_sck && !sck) idx++;
      prev_sck = sck;
      miso = (slave_en && idx < WIDTH) ? slave_word[WIDTH-1-idx] : 1'b0;
    end
  end

  // Frame monitor: observes the bus at the falling clk edge.
  int               len_q[$];
  int               sckn_q[$];
  logic [WIDTH-1:0] mosi_q[$];
  logic [WIDTH-1:0] q_q[$];
  bit               align_q[$];
  int               gap_q[$];
  int               done_cnt = 0;
  int               sck_cnt = 0;
  bit               seen_frame = 1'b0;

  initial begin
    int               low_cnt, high_cnt;
    logic [WIDTH-1:0] mosi_w;
    logic             prev_cs, prev_sck;
    low_cnt = 0; high_cnt = 0; mosi_w = '0; prev_cs = 1'b1; prev_sck = 1'b0;
    forever begin
      @(negedge clk);
      if (!cs_n) begin
        if (prev_cs) begin
          if (seen_frame) gap_q.push_back(high_cnt);
          low_cnt = 0; sck_cnt = 0; mosi_w = '0;
        end
        low_cnt++;
      end else begin
        if (!prev_cs) begin
          len_q.push_back(low_cnt);
          sckn_q.push_back(sck_cnt);
          mosi_q.push_back(mosi_w);
          seen_frame = 1'b1;
          high_cnt = 0;
        end
        high_cnt++;
      end
      if (sck && !prev_sck) begin
        mosi_w = {mosi_w[WIDTH-2:0], mosi};
        sck_cnt++;
      end
      if (done) begin
        q_q.push_back(q);
        align_q.push_back(cs_n && !prev_cs);
        done_cnt++;
      end
      prev_cs = cs_n;
      prev_sck = sck;
    end
  end

  function automatic logic [WIDTH-1:0] exp_rx(input logic [WIDTH-1:0] tx, input logic [WIDTH-1:0] sw);
`ifdef SPI_MASTER_LOOPBACK_EN
    return tx;
`else
    return sw;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    len_q.delete(); sckn_q.delete(); mosi_q.delete(); q_q.delete();
    align_q.delete(); gap_q.delete();
    done_cnt = 0;
    seen_frame = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      tick(1);
      k++;
    end
    check("done_timeout", done, 1'b1);
  endtask

  task automatic wait_bits(input int n, input int budget);
    int k;
    k = 0;
    while (!(sck_cnt >= n && !cs_n) && k < budget) begin
      tick(1);
      k++;
    end
    check("bit_wait_timeout", (sck_cnt >= n), 1'b1);
  endtask

  task automatic pulse_start(input logic [WIDTH-1:0] word);
    d = word;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [WIDTH-1:0] tx, input logic [WIDTH-1:0] rx);
    bit have;
    have = (len_q.size() > 0) && (q_q.size() > 0);
    check({tag, "_present"}, have, 1'b1);
    if (have) begin
      check({tag, "_cs_low"}, len_q.pop_front(), CS_LOW);
      check({tag, "_sck_pulses"}, sckn_q.pop_front(), WIDTH);
      check({tag, "_mosi"}, mosi_q.pop_front(), tx);
      check({tag, "_q"}, q_q.pop_front(), rx);
      check({tag, "_done_at_cs_rise"}, align_q.pop_front(), 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] tx, sw;

    // Reset and quiet idle.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("idle_ctrl", {sck, mosi, cs_n, busy, done}, 5'b00100);
      check("idle_q", q, '0);
      tick(1);
    end

    // Directed frame.
    clear_mon();
    slave_word = 32'h1234_5678;
    pulse_start(32'hA5C3_0F81);
    check("accept_busy", busy, 1'b1);
    check("accept_cs_n", cs_n, 1'b0);
    wait_done(CS_LOW + 20);
    tick(1);
    check("gap_busy_hi", busy, 1'b1);
    tick(1);
    check("gap_busy_lo", busy, 1'b0);
    check_frame("directed", 32'hA5C3_0F81, exp_rx(32'hA5C3_0F81, 32'h1234_5678));
    tick(5);
    check("q_hold", q, exp_rx(32'hA5C3_0F81, 32'h1234_5678));

    // Start and d change mid-frame are ignored.
    clear_mon();
    tx = $urandom;
    sw = $urandom;
    slave_word = sw;
    pulse_start(tx);
    wait_bits(10, CS_LOW);
    pulse_start(32'hFFFF_FFFF);
    wait_done(CS_LOW + 20);
    tick(3);
    check("midframe_busy_clear", busy, 1'b0);
    tick(300);
    check_frame("midframe", tx, exp_rx(tx, sw));
    check("midframe_one_done", done_cnt, 1);

    // Held start: back-to-back frames.
    clear_mon();
    sw = $urandom;
    slave_word = sw;
    d = 32'h0000_0001;
    start = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_done(CS_LOW + 20);
      if (f < 2) tick(1);
    end
    start = 1'b0;
    tick(300);
    check("b2b_done_count", done_cnt, 3);
    check("b2b_gap_count", gap_q.size(), 2);
    while (gap_q.size() > 0) check("b2b_cs_high", gap_q.pop_front(), IDLE_HI);
    for (int f = 0; f < 3; f++) check_frame("b2b", 32'h0000_0001, exp_rx(32'h0000_0001, sw));

    // Reset mid-frame aborts without done.
    clear_mon();
    slave_word = $urandom;
    pulse_start($urandom);
    wait_bits(16, CS_LOW);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("abort_ctrl", {sck, cs_n, busy, done}, 4'b0100);
    check("abort_q", q, '0);
    tick(300);
    check("abort_no_done", done_cnt, 0);

    // Randomized frames with random idle spacing.
    for (int r = 0; r < 4; r++) begin
      clear_mon();
      tick($urandom_range(0, 7));
      tx = $urandom;
      sw = $urandom;
      slave_word = sw;
      pulse_start(tx);
      wait_done(CS_LOW + 20);
      tick(3);
      check_frame("random", tx, exp_rx(tx, sw));
    end

`ifdef SPI_MASTER_LOOPBACK_EN
    // Self-test with no peripheral: miso stays low.
    clear_mon();
    slave_en = 1'b0;
    pulse_start(32'hDEAD_BEEF);
    wait_done(CS_LOW + 20);
    tick(3);
    check_frame("loopback", 32'hDEAD_BEEF, 32'hDEAD_BEEF);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
